spmv_lane_consumer: RTL and testbench



---
 rtl/spmv_lane_consumer.sv | 156 +++++++++++++++
 tb/tb_spmv_lane_consumer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_lane_consumer.sv
// One-lane SpMV consumer: pops len/val/col FIFOs, accumulates val*x[col] per CSR row, emits row results.
// Optional saturating accumulation and sat_flag output when SPMV_SAT_EN is defined.
module spmv_lane_consumer #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 8,
    parameter int ACC_W  = 24,
    parameter int ROW_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] val_in,
    input  logic [COL_W-1:0]  col_in,
    input  logic [DATA_W-1:0] len_in,
    input  logic              val_empty,
    input  logic              col_empty,
    input  logic              len_empty,
    output logic              val_read,
    output logic              col_read,
    output logic              len_read,
    input  logic              x_we,
    input  logic [COL_W-1:0]  x_addr,
    input  logic [DATA_W-1:0] x_data,
    output logic [ACC_W-1:0]  y_out,
    output logic [ROW_W-1:0]  y_row,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              busy
`ifdef SPMV_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    // state  | meaning
    // S_LEN  | waiting to pop the next row length
    // S_ACC  | popping (val, col) pairs and accumulating
    // S_EMIT | presenting the row result until y_ready
    typedef enum logic [1:0] {S_LEN, S_ACC, S_EMIT} state_t;

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [DATA_W-1:0]        remaining;
    logic [DATA_W-1:0]        x_rf [0:(1<<COL_W)-1];

    logic                     pair_pop;
    logic signed [DATA_W-1:0] val_s;
    logic signed [DATA_W-1:0] x_head;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_next;

    assign len_read = !rst && (state == S_LEN) && !len_empty;
    assign pair_pop = !rst && (state == S_ACC) && !val_empty && !col_empty;
    assign val_read = pair_pop;
    assign col_read = pair_pop;

    always_ff @(posedge clk) begin
        if (x_we)
            x_rf[x_addr] <= x_data;
    end

    assign val_s  = val_in;
    assign x_head = x_rf[col_in];
    assign prod   = val_s * x_head;
    // Sum is wide enough that neither operand nor the carry is lost before wrap/clamp.
    assign sum    = SUM_W'(acc) + SUM_W'(prod);

`ifdef SPMV_SAT_EN
    logic clamp;
    logic row_sat;

    always_comb begin
        acc_next = ACC_W'(sum);
        clamp    = 1'b0;
        if (!((&sum[SUM_W-1:ACC_W-1]) || !(|sum[SUM_W-1:ACC_W-1]))) begin
            clamp    = 1'b1;
            acc_next = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        acc_next = ACC_W'(sum);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LEN;
            acc       <= '0;
            remaining <= '0;
            y_out     <= '0;
            y_row     <= '0;
            y_valid   <= 1'b0;
            busy      <= 1'b0;
`ifdef SPMV_SAT_EN
            row_sat   <= 1'b0;
            sat_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                S_LEN: begin
                    if (!len_empty) begin
                        remaining <= len_in;
                        acc       <= '0;
                        busy      <= 1'b1;
`ifdef SPMV_SAT_EN
                        row_sat   <= 1'b0;
                        sat_flag  <= 1'b0;
`endif
                        if (len_in == '0) begin
                            state   <= S_EMIT;
                            y_out   <= '0;
                            y_valid <= 1'b1;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (pair_pop) begin
                        acc       <= acc_next;
                        remaining <= remaining - DATA_W'(1);
`ifdef SPMV_SAT_EN
                        row_sat   <= row_sat | clamp;
`endif
                        if (remaining == DATA_W'(1)) begin
                            state   <= S_EMIT;
                            y_out   <= acc_next;
                            y_valid <= 1'b1;
`ifdef SPMV_SAT_EN
                            sat_flag <= row_sat | clamp;
`endif
                        end
                    end
                end
                S_EMIT: begin
                    if (y_ready) begin
                        state   <= S_LEN;
                        y_valid <= 1'b0;
                        busy    <= 1'b0;
                        y_row   <= y_row + ROW_W'(1);
`ifdef SPMV_SAT_EN
                        sat_flag <= 1'b0;
`endif
                    end
                end
                default: state <= S_LEN;
            endcase
        end
    end

endmodule

// File: tb/tb_spmv_lane_consumer.sv
// Directed bench for spmv_lane_consumer: FWFT FIFO model, hand-computed row sums, stall/backpressure/reset cases.
// A second instance with ACC_W=8 covers wrap vs. saturation (SPMV_SAT_EN).
module tb_spmv_lane_consumer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  val_in, col_in, len_in;
    logic        val_empty, col_empty, len_empty;
    logic        val_read, col_read, len_read;
    logic        val_read8, col_read8, len_read8;
    logic        x_we;
    logic [7:0]  x_addr, x_data;
    logic [23:0] y_out;
    logic [7:0]  y_out8;
    logic [15:0] y_row, y_row8;
    logic        y_valid, y_valid8, y_ready, busy, busy8;
`ifdef SPMV_SAT_EN
    logic        sat_flag, sat_flag8;
`endif

    int checks = 0;
    int failures = 0;
    int n_vr = 0, n_cr = 0, n_lr = 0;
    int base_v, base_c, base_l, n;
    bit col_stall = 1'b0;
    logic [7:0] vq[$], cq[$], lq[$];

    always #5 clk = ~clk;

    spmv_lane_consumer #(.DATA_W(8), .COL_W(8), .ACC_W(24), .ROW_W(16)) dut (
        .clk(clk), .rst(rst),
        .val_in(val_in), .col_in(col_in), .len_in(len_in),
        .val_empty(val_empty), .col_empty(col_empty), .len_empty(len_empty),
        .val_read(val_read), .col_read(col_read), .len_read(len_read),
        .x_we(x_we), .x_addr(x_addr), .x_data(x_data),
        .y_out(y_out), .y_row(y_row), .y_valid(y_valid), .y_ready(y_ready),
        .busy(busy)
`ifdef SPMV_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    // Narrow-accumulator twin sees the same FIFO heads; its pop timing matches the main DUT.
    spmv_lane_consumer #(.DATA_W(8), .COL_W(8), .ACC_W(8), .ROW_W(16)) dut8 (
        .clk(clk), .rst(rst),
        .val_in(val_in), .col_in(col_in), .len_in(len_in),
        .val_empty(val_empty), .col_empty(col_empty), .len_empty(len_empty),
        .val_read(val_read8), .col_read(col_read8), .len_read(len_read8),
        .x_we(x_we), .x_addr(x_addr), .x_data(x_data),
        .y_out(y_out8), .y_row(y_row8), .y_valid(y_valid8), .y_ready(y_ready),
        .busy(busy8)
`ifdef SPMV_SAT_EN
        , .sat_flag(sat_flag8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        val_empty = (vq.size() == 0);
        col_empty = (cq.size() == 0) || col_stall;
        len_empty = (lq.size() == 0);
        val_in = (vq.size() != 0) ? vq[0] : 8'h00;
        col_in = (cq.size() != 0) ? cq[0] : 8'h00;
        len_in = (lq.size() != 0) ? lq[0] : 8'h00;
    endtask

    // Starts just after a negedge; samples reads mid-cycle, pops at the edge, returns at next negedge.
    task automatic step();
        logic rv, rc, rl;
        drive();
        #1;
        rv = val_read; rc = col_read; rl = len_read;
        if (rv === 1'b1) n_vr++;
        if (rc === 1'b1) n_cr++;
        if (rl === 1'b1) n_lr++;
        @(posedge clk);
        if (rv === 1'b1 && vq.size() != 0) void'(vq.pop_front());
        if (rc === 1'b1 && cq.size() != 0) void'(cq.pop_front());
        if (rl === 1'b1 && lq.size() != 0) void'(lq.pop_front());
        #1;
        drive();
        @(negedge clk);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (y_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic load_x(input logic [7:0] a, input logic [7:0] d);
        x_we = 1'b1; x_addr = a; x_data = d;
        step();
        x_we = 1'b0;
    endtask

    task automatic push_pair(input logic [7:0] v, input logic [7:0] c);
        vq.push_back(v);
        cq.push_back(c);
    endtask

    initial begin
        rst = 1'b1; y_ready = 1'b1; x_we = 1'b0; x_addr = '0; x_data = '0;
        drive();
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
        chk("rst_y_out", {8'd0, y_out}, 32'd0);
        chk("rst_y_row", {16'd0, y_row}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Row 0: 4*2 + 6*(-1) + 1*5 = 7
        load_x(8'd0, 8'd2);
        load_x(8'd3, 8'hFF);
        load_x(8'd7, 8'd5);
        lq.push_back(8'd3);
        push_pair(8'd4, 8'd0); push_pair(8'd6, 8'd3); push_pair(8'd1, 8'd7);
        wait_valid(n);
        chk("r0_latency", n, 32'd4);
        chk("r0_y_out", {8'd0, y_out}, 32'd7);
        chk("r0_y_row", {16'd0, y_row}, 32'd0);
        chk("r0_busy", {31'd0, busy}, 32'd1);
        chk("r0_y_out8", {24'd0, y_out8}, 32'd7);
        step();
        chk("r0_hs_valid", {31'd0, y_valid}, 32'd0);
        chk("r0_hs_row", {16'd0, y_row}, 32'd1);

        // Row 1: empty row
        base_v = n_vr;
        lq.push_back(8'd0);
        wait_valid(n);
        chk("r1_latency", n, 32'd1);
        chk("r1_y_out", {8'd0, y_out}, 32'd0);
        chk("r1_no_val_reads", n_vr - base_v, 32'd0);
        step();
        chk("r1_hs_row", {16'd0, y_row}, 32'd2);

        // Row 2: col FIFO stalled 3 cycles; 3*5 + (-2)*2 = 11
        base_v = n_vr; base_c = n_cr;
        col_stall = 1'b1;
        lq.push_back(8'd2);
        push_pair(8'd3, 8'd7); push_pair(8'hFE, 8'd0);
        step(); step(); step(); step();
        chk("r2_stall_val_reads", n_vr - base_v, 32'd0);
        chk("r2_stall_valid", {31'd0, y_valid}, 32'd0);
        col_stall = 1'b0;
        wait_valid(n);
        chk("r2_latency", n, 32'd2);
        chk("r2_y_out", {8'd0, y_out}, 32'd11);
        chk("r2_val_pops", n_vr - base_v, 32'd2);
        chk("r2_col_pops", n_cr - base_c, 32'd2);
        step();
        chk("r2_hs_row", {16'd0, y_row}, 32'd3);

        // Row 3: backpressure with the next len already waiting
        y_ready = 1'b0;
        lq.push_back(8'd1);
        push_pair(8'd1, 8'd7);
        wait_valid(n);
        chk("r3_latency", n, 32'd2);
        lq.push_back(8'd0);
        base_l = n_lr;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("r3_hold_valid", {31'd0, y_valid}, 32'd1);
            chk("r3_hold_out", {8'd0, y_out}, 32'd5);
            chk("r3_hold_row", {16'd0, y_row}, 32'd3);
        end
        chk("r3_no_len_read", n_lr - base_l, 32'd0);
        y_ready = 1'b1;
        step();
        chk("r3_hs_valid", {31'd0, y_valid}, 32'd0);
        chk("r3_hs_row", {16'd0, y_row}, 32'd4);
        wait_valid(n);
        chk("r4_latency", n, 32'd1);
        chk("r4_y_out", {8'd0, y_out}, 32'd0);
        step();
        chk("r4_hs_row", {16'd0, y_row}, 32'd5);

        // Row 5: 127*127*2 = 32258; 8-bit accumulator wraps to 0x02 or clamps to 127
        load_x(8'd9, 8'd127);
        lq.push_back(8'd2);
        push_pair(8'd127, 8'd9); push_pair(8'd127, 8'd9);
        wait_valid(n);
        chk("r5_latency", n, 32'd3);
        chk("r5_y_out", {8'd0, y_out}, 32'd32258);
        chk("r5_y_valid8", {31'd0, y_valid8}, 32'd1);
`ifdef SPMV_SAT_EN
        chk("r5_y_out8_sat", {24'd0, y_out8}, 32'd127);
        chk("r5_sat_flag8", {31'd0, sat_flag8}, 32'd1);
        chk("r5_sat_flag24", {31'd0, sat_flag}, 32'd0);
`else
        chk("r5_y_out8_wrap", {24'd0, y_out8}, 32'h02);
`endif
        step();
        chk("r5_hs_row", {16'd0, y_row}, 32'd6);
`ifdef SPMV_SAT_EN
        chk("r5_sat_flag8_clr", {31'd0, sat_flag8}, 32'd0);
`endif

        // Reset after the first pair of a len=4 row; leftover pairs feed the next len=3 row (3*x[0] = 6)
        lq.push_back(8'd4); lq.push_back(8'd3);
        for (int i = 0; i < 4; i++) push_pair(8'd1, 8'd0);
        step(); step();
        base_v = n_vr; base_c = n_cr; base_l = n_lr;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_val_read_in_rst", n_vr - base_v, 32'd0);
        chk("mr_col_read_in_rst", n_cr - base_c, 32'd0);
        chk("mr_len_read_in_rst", n_lr - base_l, 32'd0);
        chk("mr_y_valid", {31'd0, y_valid}, 32'd0);
        chk("mr_y_row", {16'd0, y_row}, 32'd0);
        chk("mr_y_out", {8'd0, y_out}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        wait_valid(n);
        chk("mr_latency", n, 32'd4);
        chk("mr_y_out_after", {8'd0, y_out}, 32'd6);
        chk("mr_y_row_after", {16'd0, y_row}, 32'd0);
        step();
        chk("mr_val_fifo_drained", vq.size(), 32'd0);
        chk("mr_hs_row", {16'd0, y_row}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
